// File: rtl/arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : arb_pkg
// Brief   : Shared types and defaults for the fetch/data memory port arbiter.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DACC   = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/req_timeout_counter.sv
//------------------------------------------------------------------------------
// Module  : req_timeout_counter
// Brief   : Counts unanswered request cycles; flags expiry at TIMEOUT.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module req_timeout_counter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign expire_o = (cnt_q == CW'(TIMEOUT));

    // Saturates at TIMEOUT so expiry stays asserted until the owner clears it.
    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expire_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mem_port_arbiter
// Brief   : Serialises core fetch and data ports onto one variable-latency
//           req/ack memory, buffers the returned word and drives stalls.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] PCF,
    input  logic          IReqF,
    input  logic          StallHzF,
    output logic [DW-1:0] InstrF,
    output logic          IStallF,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    input  logic          MemWriteM,
    input  logic          MemReadM,
    output logic [DW-1:0] ReadDataM,
    output logic          DStallM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          mem_err
);

    arb_state_e    state_q;
    logic          ivalid_q;
    logic          dvalid_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] instr_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic          w_dreq;
    logic          w_dpend;
    logic          w_ipend;
    logic          w_busy;
    logic          w_expire;
    logic          w_done;
    logic [DW-1:0] w_rdata;

    assign w_dreq  = MemReadM | MemWriteM;
    assign w_dpend = w_dreq & ~dvalid_q;
    assign w_ipend = IReqF & ~ivalid_q;
    assign w_busy  = (state_q != IDLE);

    // A real ack wins over a coincident expiry so valid data is never dropped.
    assign w_done  = w_busy & (mem_ack | w_expire);
    assign w_rdata = mem_ack ? mem_rdata : '0;

    assign IStallF = reset & IReqF & ~ivalid_q;
    assign DStallM = reset & w_dreq & ~dvalid_q;

    assign InstrF    = instr_q;
    assign ReadDataM = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_err   = err_q;

    req_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (~w_busy | w_done),
        .enable_i (mem_req_q & ~mem_ack),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ivalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            instr_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            // Buffered words are consumed only when the relevant stage advances.
            if (!DStallM) begin
                dvalid_q <= 1'b0;
            end
            if (!IStallF && !DStallM && !StallHzF) begin
                ivalid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (w_dpend) begin
                        state_q     <= DACC;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= MemWriteM;
                        mem_addr_q  <= ALUResultM;
                        mem_wdata_q <= WriteDataM;
                    end else if (w_ipend) begin
                        state_q    <= IFETCH;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= PCF;
                    end
                end
                IFETCH: begin
                    if (w_done) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        instr_q   <= w_rdata;
                        ivalid_q  <= 1'b1;
                        if (!mem_ack) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DACC: begin
                    if (w_done) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        dvalid_q  <= 1'b1;
                        if (!mem_we_q) begin
                            rdata_q <= w_rdata;
                        end
                        if (!mem_ack) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_port_arbiter
// Brief   : Self-checking bench with a memory responder and request scoreboard.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        IReqF;
    logic        StallHzF;
    logic [31:0] InstrF;
    logic        IStallF;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ReadDataM;
    logic        DStallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PCF        (PCF),
        .IReqF      (IReqF),
        .StallHzF   (StallHzF),
        .InstrF     (InstrF),
        .IStallF    (IStallF),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ReadDataM  (ReadDataM),
        .DStallM    (DStallM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mem_err    (mem_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    txn_t        exp_q[$];
    logic [31:0] mem_m [logic [31:0]];
    int          req_age   = 0;
    int          resp_wait = 0;
    bit          force_ack = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Memory model: scores each new request, then acks after resp_wait cycles.
    task automatic respond();
        txn_t t;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEADBEEF;
        end else if (mem_req) begin
            if (req_age == 0) begin
                if (exp_q.size() == 0) begin
                    chk("txn_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    t = exp_q.pop_front();
                    chk("txn_we", 32'(mem_we), 32'(t.we));
                    chk("txn_addr", mem_addr, t.addr);
                    if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
                end
            end
            if (req_age == resp_wait) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_m[mem_addr] = mem_wdata;
                    mem_rdata = 32'h0BADF00D;
                end else begin
                    mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h5A5A5A5A;
            end
            req_age++;
        end else begin
            mem_ack = 1'b0;
            req_age = 0;
        end
    endtask

    task automatic tick();
        #1;
        respond();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_free(input bit is_data, output int ncyc);
        ncyc = 0;
        #1;
        while ((is_data ? DStallM : IStallF) && ncyc < 40) begin
            respond();
            @(posedge clk);
            #2;
            ncyc++;
        end
        if (ncyc >= 40) chk("stall_bound", 32'(is_data ? DStallM : IStallF), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; PCF = 32'h8; IReqF = 1'b1; StallHzF = 1'b0;
        ALUResultM = '0; WriteDataM = '0; MemWriteM = 1'b0; MemReadM = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0;

        force_ack = 1'b1;
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_istall", 32'(IStallF), 32'd0);
        chk("rst_dstall", 32'(DStallM), 32'd0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_err", 32'(mem_err), 32'd0);
        force_ack = 1'b0; mem_ack = 1'b0; IReqF = 1'b0; reset = 1'b1;
        tick();

        // Zero-wait fetch
        mem_m[32'h8] = 32'hE3A00005;
        PCF = 32'h8; IReqF = 1'b1; resp_wait = 0;
        exp_q.push_back('{1'b0, 32'h8, 32'h0});
        wait_free(1'b0, n);
        chk("fetch0_cycles", 32'(n), 32'd2);
        chk("fetch0_instr", InstrF, 32'hE3A00005);

        // Hazard stall holds the buffered instruction
        StallHzF = 1'b1;
        tick(); tick();
        chk("hz_istall", 32'(IStallF), 32'd0);
        chk("hz_mem_req", 32'(mem_req), 32'd0);
        chk("hz_instr", InstrF, 32'hE3A00005);
        StallHzF = 1'b0;
        tick();

        // Fetch with one wait cycle
        mem_m[32'hC] = 32'hE1A00000;
        PCF = 32'hC; resp_wait = 1;
        exp_q.push_back('{1'b0, 32'hC, 32'h0});
        wait_free(1'b0, n);
        chk("fetch1_cycles", 32'(n), 32'd3);
        chk("fetch1_instr", InstrF, 32'hE1A00000);
        IReqF = 1'b0;
        tick();

        // Fetch/store conflict: data first, then fetch
        mem_m[32'h10] = 32'hE2811001;
        PCF = 32'h10; IReqF = 1'b1;
        ALUResultM = 32'h64; WriteDataM = 32'h7; MemWriteM = 1'b1; resp_wait = 0;
        exp_q.push_back('{1'b1, 32'h64, 32'h7});
        exp_q.push_back('{1'b0, 32'h10, 32'h0});
        wait_free(1'b1, n);
        chk("conf_store_cycles", 32'(n), 32'd2);
        chk("conf_istall_held", 32'(IStallF), 32'd1);
        tick();
        MemWriteM = 1'b0;
        wait_free(1'b0, n);
        chk("conf_instr", InstrF, 32'hE2811001);
        IReqF = 1'b0;
        tick();

        // Load with three wait cycles, reads back the stored word
        MemReadM = 1'b1; ALUResultM = 32'h64; resp_wait = 3;
        exp_q.push_back('{1'b0, 32'h64, 32'h0});
        wait_free(1'b1, n);
        chk("load_cycles", 32'(n), 32'd5);
        chk("load_rdata", ReadDataM, 32'h7);
        tick();
        #1;
        chk("load_dvalid_cleared", 32'(DStallM), 32'd1);
        MemReadM = 1'b0;
        tick();
        chk("pre_to_err", 32'(mem_err), 32'd0);

        // Timeout: no ack ever arrives
        mem_m[32'h20] = 32'h12345678;
        MemReadM = 1'b1; ALUResultM = 32'h20; resp_wait = 99;
        exp_q.push_back('{1'b0, 32'h20, 32'h0});
        wait_free(1'b1, n);
        chk("to_cycles", 32'(n), 32'd6);
        chk("to_rdata", ReadDataM, 32'h0);
        chk("to_err", 32'(mem_err), 32'd1);
        MemReadM = 1'b0;
        tick(); tick();
        chk("to_err_sticky", 32'(mem_err), 32'd1);
        chk("to_mem_req", 32'(mem_req), 32'd0);

        // Reset in the middle of a fetch, then a stray ack in IDLE
        PCF = 32'h30; IReqF = 1'b1;
        exp_q.push_back('{1'b0, 32'h30, 32'h0});
        tick(); tick();
        chk("mid_mem_req", 32'(mem_req), 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_err", 32'(mem_err), 32'd0);
        chk("mid_rst_istall", 32'(IStallF), 32'd0);
        reset = 1'b1; IReqF = 1'b0; force_ack = 1'b1;
        tick();
        force_ack = 1'b0; mem_ack = 1'b0;
        tick();
        chk("stray_ack_instr", InstrF, 32'h0);
        chk("stray_ack_mem_req", 32'(mem_req), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
